// File: rtl/trojan1_multicounter_host_pkg.sv
// Shared definitions for the multi-channel counter hosts: per-channel FSM
// state encodings and the reset value of every channel limit register.
`default_nettype none

package trojan1_multicounter_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNT     = 2'd1,
    ST_UNDERFLOW = 2'd2,
    ST_OVERFLOW  = 2'd3
  } state_e;

  // Hosts slice the low COUNTER_WIDTH bits, so the limit resets to all-ones.
  localparam int unsigned MAX_COUNTER_WIDTH = 64;
  localparam logic [MAX_COUNTER_WIDTH-1:0] DEFAULT_LIMIT = '1;

endpackage

`default_nettype wire

// File: rtl/trojan1_multicounter_host_trojan1.sv
// Trojan1 trigger stage: registers the r1 condition, giving a trigger that
// follows r1 by one clock.
`default_nettype none

module trojan1_multicounter_host_trojan1 (
  input  logic clk,
  input  logic rst,
  input  logic r1,
  output logic trigger
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trigger <= 1'b0;
    end else begin
      trigger <= r1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/trojan1_multicounter_host.sv
// Multi-channel up/down counter host with per-channel limit, wrap/saturate
// terminal behaviour, one-cycle overflow/underflow pulses and the Trojan1 hook.
`default_nettype none

module trojan1_multicounter_host
  import trojan1_multicounter_host_pkg::*;
#(
  parameter int COUNTER_WIDTH = 16,
  parameter int CHANNELS      = 4,
  parameter int SEL_WIDTH     = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS-1:0]                 count_enable,
  input  logic [CHANNELS-1:0]                 count_direction,
  input  logic [CHANNELS-1:0]                 wrap_mode,
  input  logic [SEL_WIDTH-1:0]                ch_sel,
  input  logic                                load_enable,
  input  logic [COUNTER_WIDTH-1:0]            load_value,
  input  logic                                limit_we,
  output logic [CHANNELS*COUNTER_WIDTH-1:0]   counter_values,
  output logic [CHANNELS-1:0]                 counter_overflow,
  output logic [CHANNELS-1:0]                 counter_underflow
);

  logic [CHANNELS*COUNTER_WIDTH-1:0] cnt_all;
  logic [COUNTER_WIDTH-1:0]          cnt0;
  logic                              r1;
  logic                              trigger;

  assign cnt0 = cnt_all[COUNTER_WIDTH-1:0];
  assign r1   = cnt0[COUNTER_WIDTH-1] & cnt0[0];

  trojan1_multicounter_host_trojan1 u_trojan1 (
    .clk     (clk),
    .rst     (rst),
    .r1      (r1),
    .trigger (trigger)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e                   state_q;
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] lim_q;
    logic                     of_q;
    logic                     uf_q;
    logic                     sel_hit;
    logic                     ld_hit;
    logic                     lim_hit;
    logic                     force_hit;
    logic [COUNTER_WIDTH-1:0] ld_clamped;

    assign sel_hit   = (ch_sel == SEL_WIDTH'(i));
    assign ld_hit    = load_enable & sel_hit;
    assign lim_hit   = limit_we & sel_hit;
    assign force_hit = (i == 0) ? trigger : 1'b0;
    // Clamp uses the limit held before this edge, so a same-cycle limit
    // write does not affect the load.
    assign ld_clamped = (load_value > lim_q) ? lim_q : load_value;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        lim_q   <= DEFAULT_LIMIT[COUNTER_WIDTH-1:0];
        of_q    <= 1'b0;
        uf_q    <= 1'b0;
      end else begin
        if (lim_hit) begin
          lim_q <= load_value;
        end

        if (force_hit) begin
          state_q <= ST_UNDERFLOW;
          cnt_q   <= '0;
          of_q    <= 1'b0;
          uf_q    <= 1'b1;
        end else if (ld_hit) begin
          state_q <= ST_IDLE;
          cnt_q   <= ld_clamped;
          of_q    <= 1'b0;
          uf_q    <= 1'b0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              of_q <= 1'b0;
              uf_q <= 1'b0;
              if (count_enable[i]) begin
                state_q <= ST_COUNT;
              end
            end
            ST_COUNT: begin
              of_q <= 1'b0;
              uf_q <= 1'b0;
              if (!count_enable[i]) begin
                state_q <= ST_IDLE;
              end else if (!count_direction[i]) begin
                // ">=" also catches a count left above a freshly lowered limit.
                if (cnt_q >= lim_q) begin
                  of_q    <= 1'b1;
                  cnt_q   <= wrap_mode[i] ? lim_q : '0;
                  state_q <= ST_OVERFLOW;
                end else begin
                  cnt_q <= cnt_q + COUNTER_WIDTH'(1);
                end
              end else begin
                if (cnt_q == '0) begin
                  uf_q    <= 1'b1;
                  cnt_q   <= wrap_mode[i] ? '0 : lim_q;
                  state_q <= ST_UNDERFLOW;
                end else begin
                  cnt_q <= cnt_q - COUNTER_WIDTH'(1);
                end
              end
            end
            ST_OVERFLOW, ST_UNDERFLOW: begin
              of_q    <= 1'b0;
              uf_q    <= 1'b0;
              state_q <= ST_IDLE;
            end
            default: begin
              of_q    <= 1'b0;
              uf_q    <= 1'b0;
              state_q <= ST_IDLE;
            end
          endcase
        end
      end
    end

    assign cnt_all[i*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt_q;
    assign counter_overflow[i]  = of_q;
    assign counter_underflow[i] = uf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_values <= '0;
    end else begin
      counter_values <= cnt_all;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trojan1_multicounter_host.sv
// Self-checking bench for trojan1_multicounter_host: directed vector table,
// hand sequences for the corner cases, then randomized traffic against a model.
`default_nettype none

module tb_trojan1_multicounter_host;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   en, dir, wrp;
  logic [1:0]     sel;
  logic           ld, lwe;
  logic [W-1:0]   lv;
  logic [N*W-1:0] cv;
  logic [N-1:0]   of, uf;

  always #5 clk = ~clk;

  trojan1_multicounter_host #(
    .COUNTER_WIDTH (W),
    .CHANNELS      (N),
    .SEL_WIDTH     (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .count_enable      (en),
    .count_direction   (dir),
    .wrap_mode         (wrp),
    .ch_sel            (sel),
    .load_enable       (ld),
    .load_value        (lv),
    .limit_we          (lwe),
    .counter_values    (cv),
    .counter_overflow  (of),
    .counter_underflow (uf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: mode 0 = idle, 1 = running, 2 = pulse just emitted.
  logic [W-1:0]   m_cnt [N];
  logic [W-1:0]   m_lim [N];
  int             m_mode[N];
  logic [N-1:0]   m_of, m_uf;
  logic           m_trig;
  logic [N*W-1:0] m_cv;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i]  = '0;
      m_lim[i]  = '1;
      m_mode[i] = 0;
    end
    m_of   = '0;
    m_uf   = '0;
    m_trig = 1'b0;
    m_cv   = '0;
  endtask

  task automatic model_step();
    logic [W-1:0] prev [N];
    logic [N-1:0] nof, nuf;
    for (int i = 0; i < N; i++) prev[i] = m_cnt[i];
    for (int i = 0; i < N; i++) begin
      nof[i] = 1'b0;
      nuf[i] = 1'b0;
      if (i == 0 && m_trig) begin
        m_cnt[0]  = '0;
        nuf[0]    = 1'b1;
        m_mode[0] = 2;
      end else if (ld && int'(sel) == i) begin
        m_cnt[i]  = (lv < m_lim[i]) ? lv : m_lim[i];
        m_mode[i] = 0;
      end else if (m_mode[i] == 1 && en[i]) begin
        if (!dir[i]) begin
          if (prev[i] >= m_lim[i]) begin
            nof[i]    = 1'b1;
            m_cnt[i]  = wrp[i] ? m_lim[i] : '0;
            m_mode[i] = 2;
          end else begin
            m_cnt[i] = prev[i] + 1'b1;
          end
        end else begin
          if (prev[i] == 0) begin
            nuf[i]    = 1'b1;
            m_cnt[i]  = wrp[i] ? '0 : m_lim[i];
            m_mode[i] = 2;
          end else begin
            m_cnt[i] = prev[i] - 1'b1;
          end
        end
      end else if (m_mode[i] == 0 && en[i]) begin
        m_mode[i] = 1;
      end else begin
        m_mode[i] = 0;
      end
    end
    if (lwe) m_lim[sel] = lv;
    m_trig = prev[0][W-1] & prev[0][0];
    for (int i = 0; i < N; i++) m_cv[i*W +: W] = prev[i];
    m_of = nof;
    m_uf = nuf;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("cv", cv, m_cv);
    chk("of", of, m_of);
    chk("uf", uf, m_uf);
  endtask

  task automatic set_idle();
    en = '0; dir = '0; wrp = '0; sel = '0; ld = 1'b0; lwe = 1'b0; lv = '0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_cv", cv, 64'd0);
    chk("rst_of", of, 64'd0);
    chk("rst_uf", uf, 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic setup_limits3();
    for (int c = 0; c < N; c++) begin
      sel = 2'(c); lwe = 1'b1; lv = 16'd3; cyc();
    end
    lwe = 1'b0;
    for (int c = 0; c < N; c++) begin
      sel = 2'(c); ld = 1'b1; lv = 16'd3; cyc();
    end
    ld = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  en;
    logic [1:0]  sel;
    logic        ld;
    logic        lwe;
    logic [15:0] lv;
    logic [15:0] exp_cv1;
    logic [3:0]  exp_of;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{4'b0000, 2'd1, 1'b0, 1'b1, 16'd5, 16'd0, 4'b0000};
    tbl[1] = '{4'b0000, 2'd1, 1'b1, 1'b0, 16'd3, 16'd0, 4'b0000};
    tbl[2] = '{4'b0010, 2'd1, 1'b0, 1'b0, 16'd0, 16'd3, 4'b0000};
    tbl[3] = '{4'b0010, 2'd1, 1'b0, 1'b0, 16'd0, 16'd3, 4'b0000};
    tbl[4] = '{4'b0010, 2'd1, 1'b0, 1'b0, 16'd0, 16'd4, 4'b0000};
    tbl[5] = '{4'b0010, 2'd1, 1'b0, 1'b0, 16'd0, 16'd5, 4'b0010};
    tbl[6] = '{4'b0010, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0, 4'b0000};
    tbl[7] = '{4'b0000, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0, 4'b0000};

    set_idle();
    model_reset();
    do_reset();

    // limit[1]=5, load 3, count up to overflow
    for (int k = 0; k < 8; k++) begin
      en = tbl[k].en; sel = tbl[k].sel; ld = tbl[k].ld;
      lwe = tbl[k].lwe; lv = tbl[k].lv;
      cyc();
      chk("tbl_cv1", cv[31:16], tbl[k].exp_cv1);
      chk("tbl_of", of, tbl[k].exp_of);
    end

    // ch2 down: saturate then wrap
    set_idle(); do_reset();
    wrp = 4'b0100; sel = 2'd2; ld = 1'b1; lv = 16'd1; cyc();
    ld = 1'b0; en = 4'b0100; dir = 4'b0100; cyc(); cyc(); cyc();
    chk("sat_uf", uf, 4'b0100);
    cyc();
    chk("sat_uf_clr", uf, 4'b0000);
    chk("sat_cnt", cv[47:32], 16'h0000);
    en = '0; wrp = '0; ld = 1'b1; lv = 16'd1; cyc();
    ld = 1'b0; en = 4'b0100; cyc(); cyc(); cyc();
    chk("wrap_uf", uf, 4'b0100);
    cyc();
    chk("wrap_cnt", cv[47:32], 16'hFFFF);

    // ch0 load clamping and same-cycle limit write
    set_idle(); do_reset();
    sel = 2'd0; lwe = 1'b1; lv = 16'h00FF; cyc();
    lwe = 1'b0; ld = 1'b1; lv = 16'h0100; cyc();
    ld = 1'b0; cyc();
    chk("clamp", cv[15:0], 16'h00FF);
    lwe = 1'b1; ld = 1'b1; lv = 16'h0010; cyc();
    lwe = 1'b0; ld = 1'b0; cyc();
    chk("old_lim_clamp", cv[15:0], 16'h0010);
    en = 4'b0001; cyc(); cyc();
    chk("new_lim_of", of, 4'b0001);
    en = '0; cyc();

    // all channels overflow together, then ch3 load wins
    set_idle(); do_reset();
    setup_limits3();
    en = 4'b1111; cyc(); cyc();
    chk("all_of", of, 4'b1111);
    set_idle(); do_reset();
    setup_limits3();
    en = 4'b1111; cyc();
    sel = 2'd3; ld = 1'b1; lv = 16'd1; cyc();
    chk("ld3_of", of, 4'b0111);
    ld = 1'b0; en = '0; cyc();
    chk("ld3_cnt", cv[63:48], 16'd1);

    // Trojan trigger on ch0 only
    set_idle(); do_reset();
    sel = 2'd0; ld = 1'b1; lv = 16'h8000; cyc();
    sel = 2'd1; lv = 16'h0010; cyc();
    ld = 1'b0; en = 4'b1111; cyc(); cyc(); cyc(); cyc();
    chk("troj_uf", uf, 4'b0001);
    cyc();
    chk("troj_cnt0", cv[15:0], 16'h0000);
    chk("troj_others", cv[63:16], {16'd3, 16'd3, 16'h0013});

    // reset mid-count, resume two cycles after enable
    cyc(); cyc();
    do_reset();
    cyc();
    chk("rs_cv0", cv, 64'd0);
    cyc(); cyc();
    chk("rs_resume", cv, {4{16'd1}});
    en = '0; sel = 2'd2; ld = 1'b1; lv = 16'hFFFF; cyc();
    ld = 1'b0; cyc();
    chk("rs_lim", cv[47:32], 16'hFFFF);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      en  = 4'($urandom() | $urandom());
      dir = 4'($urandom());
      wrp = 4'($urandom());
      sel = 2'($urandom());
      ld  = ($urandom_range(0, 7) == 0);
      lwe = ($urandom_range(0, 7) == 0);
      lv  = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 20));
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cyc();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
